uart_frame_tx: RTL and testbench

UART_FRAME_TX -- requirements
Module: uart_frame_tx

---
 rtl/uart_frame_tx.sv | 135 +++++++++++++
 tb/tb_uart_frame_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_tx.sv
// Serial frame transmitter: sends HEADER followed by four latched payload bytes as 8N1, LSB first.
// Optional macro UART_TX_CHKSUM_EN appends a sixth byte holding the mod-256 sum of the payload.
module uart_frame_tx #(
  parameter int unsigned CLK_DIV = 434,
  parameter logic [7:0]  HEADER  = 8'hA5
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic [7:0] DataTX_1,
  input  logic [7:0] DataTX_2,
  input  logic [7:0] DataTX_3,
  input  logic [7:0] DataTX_4,
  input  logic       EnTxData,
  output logic       TxD,
  output logic       busy,
  output logic       tx_done,
  output logic       ovr
);

`ifdef UART_TX_CHKSUM_EN
  localparam int unsigned NUM_BYTES = 6;
`else
  localparam int unsigned NUM_BYTES = 5;
`endif
  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(NUM_BYTES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BYTES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]                 state, state_nxt;
  logic [CNT_W-1:0]           cnt, cnt_nxt;
  logic [2:0]                 bit_idx, bit_nxt;
  logic [IDX_W-1:0]           byte_idx, byte_nxt;
  logic [NUM_BYTES-1:0][7:0]  frm, frm_nxt;
  logic                       txd_nxt, busy_nxt, tx_done_nxt, ovr_nxt;
  logic                       bit_end;

  assign bit_end = (cnt == CNT_LAST);

`ifdef UART_TX_CHKSUM_EN
  logic [7:0] chksum_c;
  assign chksum_c = DataTX_1 + DataTX_2 + DataTX_3 + DataTX_4;
`endif

  // Next-state logic; outputs are computed from the state being entered so they can be registered.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    bit_nxt   = bit_idx;
    byte_nxt  = byte_idx;
    frm_nxt   = frm;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (EnTxData) begin
          state_nxt  = START;
          byte_nxt   = '0;
          frm_nxt[0] = HEADER;
          frm_nxt[1] = DataTX_1;
          frm_nxt[2] = DataTX_2;
          frm_nxt[3] = DataTX_3;
          frm_nxt[4] = DataTX_4;
`ifdef UART_TX_CHKSUM_EN
          frm_nxt[5] = chksum_c;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          cnt_nxt   = '0;
          bit_nxt   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 bit_nxt   = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (byte_idx == IDX_LAST) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = START;
            byte_nxt  = byte_idx + IDX_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    case (state_nxt)
      START:   txd_nxt = 1'b0;
      DATA:    txd_nxt = frm[byte_nxt][bit_nxt];
      default: txd_nxt = 1'b1;
    endcase
    busy_nxt    = (state_nxt != IDLE);
    tx_done_nxt = (state_nxt == STOP) && (cnt_nxt == CNT_LAST) && (byte_nxt == IDX_LAST);
    ovr_nxt     = EnTxData && busy;
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      frm      <= '0;
      TxD      <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_nxt;
      byte_idx <= byte_nxt;
      frm      <= frm_nxt;
      TxD      <= txd_nxt;
      busy     <= busy_nxt;
      tx_done  <= tx_done_nxt;
      ovr      <= ovr_nxt;
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Testbench for uart_frame_tx: random payloads compared against a bit-time reference model.
module tb_uart_frame_tx;

`ifdef UART_TX_CHKSUM_EN
  localparam int NB     = 6;
  localparam int T_SPEC = 240;
`else
  localparam int NB     = 5;
  localparam int T_SPEC = 200;
`endif
  localparam int DIV     = 4;
  localparam int DIV_S   = 434;
  localparam int T       = NB * 10 * DIV;
  localparam int T_S     = NB * 10 * DIV_S;
  localparam logic [7:0] HDR = 8'hA5;

  logic       clk_50m, rst, EnTxData, en_s;
  logic [7:0] DataTX_1, DataTX_2, DataTX_3, DataTX_4;
  logic [7:0] ds1, ds2, ds3, ds4;
  logic       TxD, busy, tx_done, ovr;
  logic       txd_s, busy_s, done_s, ovr_s;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int txd_err, busy_err, done_cnt, done_at, ovr_cnt, ovr_at, first_bad;

  uart_frame_tx #(.CLK_DIV(DIV), .HEADER(HDR)) dut (
    .clk_50m(clk_50m), .rst(rst),
    .DataTX_1(DataTX_1), .DataTX_2(DataTX_2), .DataTX_3(DataTX_3), .DataTX_4(DataTX_4),
    .EnTxData(EnTxData), .TxD(TxD), .busy(busy), .tx_done(tx_done), .ovr(ovr)
  );

  uart_frame_tx #(.CLK_DIV(DIV_S), .HEADER(HDR)) u_slow (
    .clk_50m(clk_50m), .rst(rst),
    .DataTX_1(ds1), .DataTX_2(ds2), .DataTX_3(ds3), .DataTX_4(ds4),
    .EnTxData(en_s), .TxD(txd_s), .busy(busy_s), .tx_done(done_s), .ovr(ovr_s)
  );

  initial clk_50m = 1'b0;
  always #10 clk_50m = ~clk_50m;

  // Whole frame as bytes, byte 0 in the low bits.
  function automatic logic [NB*8-1:0] make_frame(input logic [7:0] b1, b2, b3, b4);
    logic [NB*8-1:0] f;
    f = '0;
    f[7:0]   = HDR;
    f[15:8]  = b1;
    f[23:16] = b2;
    f[31:24] = b3;
    f[39:32] = b4;
`ifdef UART_TX_CHKSUM_EN
    f[47:40] = 8'((int'(b1) + int'(b2) + int'(b3) + int'(b4)) % 256);
`endif
    return f;
  endfunction

  // Expected line level k cycles after acceptance (k=1 is the first start-bit cycle).
  function automatic logic exp_txd(input logic [NB*8-1:0] fr, input int div, input int k);
    int bt, by, pos;
    bt  = (k - 1) / div;
    by  = bt / 10;
    pos = bt % 10;
    if (by >= NB) return 1'b1;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return fr[by*8 + pos - 1];
  endfunction

  // Drive one request and observe T+2 cycles; optional second request at req_at, DataTX_1 change at mut_at.
  task automatic run_frame(input logic [7:0] b1, b2, b3, b4, input int req_at, input int mut_at, input bit rel);
    logic [NB*8-1:0] fr;
    fr = make_frame(b1, b2, b3, b4);
    txd_err = 0; busy_err = 0; done_cnt = 0; done_at = -1; ovr_cnt = 0; ovr_at = -1; first_bad = -1;
    @(negedge clk_50m);
    if (rel) rst = 1'b0;
    DataTX_1 = b1; DataTX_2 = b2; DataTX_3 = b3; DataTX_4 = b4;
    EnTxData = 1'b1;
    for (int k = 1; k <= T + 2; k++) begin
      @(negedge clk_50m);
      if (TxD !== exp_txd(fr, DIV, k)) begin
        txd_err++;
        if (first_bad < 0) first_bad = k;
      end
      if (busy !== (k <= T)) busy_err++;
      if (tx_done === 1'b1) begin done_cnt++; done_at = k; end
      if (ovr === 1'b1) begin
        ovr_cnt++;
        if (ovr_at < 0) ovr_at = k;
      end
      EnTxData = (k == req_at);
      if (k == mut_at) DataTX_1 = 8'hFF;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3;
    chk_cnt++; if (TxD !== 1'b1) $display("FAIL reset_txd: got %b want 1", TxD); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (tx_done !== 1'b0) $display("FAIL reset_done: got %b want 0", tx_done); else pass_cnt++;
    chk_cnt++; if (ovr !== 1'b0) $display("FAIL reset_ovr: got %b want 0", ovr); else pass_cnt++;
    repeat (2) @(negedge clk_50m);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    run_frame(8'h01, 8'h02, 8'h03, 8'h04, 0, 0, 1'b0);
    chk_cnt++; if (txd_err !== 0) $display("FAIL basic_txd: %0d bad cycles (first k=%0d), want 0", txd_err, first_bad); else pass_cnt++;
    chk_cnt++; if (busy_err !== 0) $display("FAIL basic_busy: %0d bad cycles, want 0", busy_err); else pass_cnt++;
    chk_cnt++; if (done_cnt !== 1) $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); else pass_cnt++;
    chk_cnt++; if (done_at !== T_SPEC) $display("FAIL basic_done_at: got %0d want %0d", done_at, T_SPEC); else pass_cnt++;
    chk_cnt++; if (ovr_cnt !== 0) $display("FAIL basic_ovr: got %0d want 0", ovr_cnt); else pass_cnt++;
  endtask

  task automatic test_random;
    for (int i = 0; i < 4; i++) begin
      run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 1'b0);
      chk_cnt++; if (txd_err !== 0) $display("FAIL rand%0d_txd: %0d bad cycles (first k=%0d), want 0", i, txd_err, first_bad); else pass_cnt++;
      chk_cnt++; if (done_at !== T) $display("FAIL rand%0d_done_at: got %0d want %0d", i, done_at, T); else pass_cnt++;
    end
  endtask

  task automatic test_overrun;
    run_frame(8'h01, 8'h02, 8'h03, 8'h04, 50, 0, 1'b0);
    chk_cnt++; if (ovr_cnt !== 1) $display("FAIL ovr_mid_cnt: got %0d want 1", ovr_cnt); else pass_cnt++;
    chk_cnt++; if (ovr_at !== 51) $display("FAIL ovr_mid_at: got %0d want 51", ovr_at); else pass_cnt++;
    chk_cnt++; if (txd_err !== 0) $display("FAIL ovr_mid_txd: %0d bad cycles, want 0", txd_err); else pass_cnt++;
    run_frame(8'h01, 8'h02, 8'h03, 8'h04, T, 0, 1'b0);
    chk_cnt++; if (ovr_cnt !== 1) $display("FAIL ovr_done_cnt: got %0d want 1", ovr_cnt); else pass_cnt++;
    chk_cnt++; if (ovr_at !== T + 1) $display("FAIL ovr_done_at: got %0d want %0d", ovr_at, T + 1); else pass_cnt++;
    chk_cnt++; if (busy_err !== 0) $display("FAIL ovr_done_no_requeue: %0d bad busy cycles, want 0", busy_err); else pass_cnt++;
    chk_cnt++; if (done_cnt !== 1) $display("FAIL ovr_done_pulses: got %0d want 1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_data_change;
    run_frame(8'h01, 8'h02, 8'h03, 8'h04, 0, 20, 1'b0);
    chk_cnt++; if (txd_err !== 0) $display("FAIL latch_txd: %0d bad cycles (first k=%0d), want 0", txd_err, first_bad); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int ocnt;
    logic b_gap, b_next, t_next;
    ocnt = 0;
    @(negedge clk_50m);
    DataTX_1 = 8'h11; DataTX_2 = 8'h22; DataTX_3 = 8'h33; DataTX_4 = 8'h44;
    EnTxData = 1'b1;
    for (int k = 1; k <= T + 2; k++) begin
      @(negedge clk_50m);
      if (k <= T + 1 && ovr === 1'b1) ocnt++;
      if (k == T + 1) b_gap = busy;
      if (k == T + 2) begin b_next = busy; t_next = TxD; end
    end
    EnTxData = 1'b0;
    chk_cnt++; if (ocnt !== T) $display("FAIL b2b_ovr_cnt: got %0d want %0d", ocnt, T); else pass_cnt++;
    chk_cnt++; if (b_gap !== 1'b0) $display("FAIL b2b_idle_gap: busy %b want 0", b_gap); else pass_cnt++;
    chk_cnt++; if (b_next !== 1'b1 || t_next !== 1'b0) $display("FAIL b2b_restart: busy %b txd %b want 1 0", b_next, t_next); else pass_cnt++;
    repeat (T + 4) @(negedge clk_50m);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL b2b_single_second: busy %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int bad;
    bad = 0;
    @(negedge clk_50m);
    DataTX_1 = 8'h01; DataTX_2 = 8'h02; DataTX_3 = 8'h03; DataTX_4 = 8'h04;
    EnTxData = 1'b1;
    repeat (100) begin
      @(negedge clk_50m);
      EnTxData = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk_cnt++; if (TxD !== 1'b1 || busy !== 1'b0) $display("FAIL rst_async: txd %b busy %b want 1 0", TxD, busy); else pass_cnt++;
    repeat (5) begin
      @(negedge clk_50m);
      if (tx_done !== 1'b0 || busy !== 1'b0 || TxD !== 1'b1) bad++;
    end
    chk_cnt++; if (bad !== 0) $display("FAIL rst_hold: %0d bad cycles, want 0", bad); else pass_cnt++;
    run_frame(8'h01, 8'h02, 8'h03, 8'h04, 0, 0, 1'b1);
    chk_cnt++; if (txd_err !== 0) $display("FAIL rst_after_txd: %0d bad cycles (first k=%0d), want 0", txd_err, first_bad); else pass_cnt++;
    chk_cnt++; if (done_at !== T_SPEC) $display("FAIL rst_after_done: got %0d want %0d", done_at, T_SPEC); else pass_cnt++;
  endtask

  task automatic test_slow;
    logic [NB*8-1:0] fr;
    int err, dat, ob;
    logic t434, t435, b_end;
    err = 0; dat = -1; ob = 0;
    ds1 = 8'h55; ds2 = 8'($urandom); ds3 = 8'($urandom); ds4 = 8'($urandom);
    fr = make_frame(ds1, ds2, ds3, ds4);
    @(negedge clk_50m);
    en_s = 1'b1;
    for (int k = 1; k <= T_S + 1; k++) begin
      @(negedge clk_50m);
      en_s = 1'b0;
      if (txd_s !== exp_txd(fr, DIV_S, k)) err++;
      if (k == 434) t434 = txd_s;
      if (k == 435) t435 = txd_s;
      if (done_s === 1'b1) dat = k;
      if (ovr_s !== 1'b0) ob++;
      if (k == T_S + 1) b_end = busy_s;
    end
    chk_cnt++; if (t434 !== 1'b0 || t435 !== 1'b1) $display("FAIL slow_start_width: k434 %b k435 %b want 0 1", t434, t435); else pass_cnt++;
    chk_cnt++; if (err !== 0) $display("FAIL slow_txd: %0d bad cycles, want 0", err); else pass_cnt++;
    chk_cnt++; if (dat !== T_S) $display("FAIL slow_done_at: got %0d want %0d", dat, T_S); else pass_cnt++;
    chk_cnt++; if (b_end !== 1'b0 || ob !== 0) $display("FAIL slow_end: busy %b ovr pulses %0d want 0 0", b_end, ob); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; EnTxData = 1'b0; en_s = 1'b0;
    DataTX_1 = 8'h00; DataTX_2 = 8'h00; DataTX_3 = 8'h00; DataTX_4 = 8'h00;
    ds1 = 8'h00; ds2 = 8'h00; ds3 = 8'h00; ds4 = 8'h00;
    test_reset();
    test_basic();
    test_random();
    test_overrun();
    test_data_change();
    test_back_to_back();
    test_reset_mid();
    test_slow();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
